// File: rtl/hwpe_ctrl_regfile_mbist_wrap.sv
// Regfile (latch- or FF-style) with an embedded March C- BIST engine sharing its single port.
// Latency: reads return data the cycle after a granted read; a march takes 10*NumWords+1 cycles.
// Backpressure: gnt_o is held low for functional requests while the engine owns the array.
module hwpe_ctrl_regfile_mbist_wrap #(
  parameter int RegfileScm = 1,
  parameter int AddrWidth  = 5,
  parameter int DataWidth  = 32,
  parameter int NumWords   = 32,
  parameter int CntWidth   = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                clear_i,
  input  logic                                req_i,
  output logic                                gnt_o,
  input  logic                                wen_i,
  input  logic [AddrWidth-1:0]                addr_i,
  input  logic [DataWidth-1:0]                wdata_i,
  input  logic [DataWidth/8-1:0]              be_i,
  output logic [DataWidth-1:0]                rdata_o,
  output logic [(2**AddrWidth)*DataWidth-1:0] mem_content_o,
  input  logic                                bist_start_i,
  output logic                                bist_busy_o,
  output logic                                bist_done_o,
  output logic                                bist_fail_o,
  output logic [AddrWidth-1:0]                bist_fail_addr_o,
  output logic [CntWidth-1:0]                 bist_err_cnt_o
);

  localparam int NumRows = 2**AddrWidth;
  localparam int NumBe   = DataWidth/8;
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords-1);

  typedef enum logic [3:0] {
    IDLE, W0, UR0W1, UR1W0, DR0W1, DR1W0, R0, DRAIN, DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic                   phase_q, phase_d;

  // element descriptor decoded from the current state
  logic                   elem_act, elem_rd, elem_exp, elem_wr, elem_wval, elem_dn;
  state_t                 elem_nxt;
  logic [AddrWidth-1:0]   elem_start;
  logic                   elem_last;

  logic                   eng_re, eng_we, busy, start_acc;

  logic                   cmp_vld_q, cmp_exp_q;
  logic [AddrWidth-1:0]   cmp_addr_q;
  logic                   done_q, fail_q;
  logic [AddrWidth-1:0]   fail_addr_q;
  logic [CntWidth-1:0]    err_cnt_q;

  logic [NumRows*DataWidth-1:0] mem_q;
  logic [DataWidth-1:0]   rdata_q;

  logic                   mem_we, mem_re;
  logic [AddrWidth-1:0]   mem_addr;
  logic [DataWidth-1:0]   mem_wdata;
  logic [NumBe-1:0]       mem_be;

  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign start_acc = bist_start_i && !busy && !clear_i;

  // State, address counter and read/write phase of two-cycle elements
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
    end
  end

  // March sequencing: decode the element, issue its read/write, advance address or element
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    phase_d    = phase_q;
    eng_re     = 1'b0;
    eng_we     = 1'b0;
    elem_act   = 1'b0;
    elem_rd    = 1'b0;
    elem_exp   = 1'b0;
    elem_wr    = 1'b0;
    elem_wval  = 1'b0;
    elem_dn    = 1'b0;
    elem_nxt   = IDLE;
    elem_start = '0;
    case (state_q)
      W0:    begin elem_act = 1'b1; elem_wr = 1'b1; elem_nxt = UR0W1; end
      UR0W1: begin elem_act = 1'b1; elem_rd = 1'b1; elem_wr = 1'b1; elem_wval = 1'b1;
                   elem_nxt = UR1W0; end
      UR1W0: begin elem_act = 1'b1; elem_rd = 1'b1; elem_exp = 1'b1; elem_wr = 1'b1;
                   elem_nxt = DR0W1; elem_start = LastAddr; end
      DR0W1: begin elem_act = 1'b1; elem_rd = 1'b1; elem_wr = 1'b1; elem_wval = 1'b1;
                   elem_dn = 1'b1; elem_nxt = DR1W0; elem_start = LastAddr; end
      DR1W0: begin elem_act = 1'b1; elem_rd = 1'b1; elem_exp = 1'b1; elem_wr = 1'b1;
                   elem_dn = 1'b1; elem_nxt = R0; end
      R0:    begin elem_act = 1'b1; elem_rd = 1'b1; elem_nxt = DRAIN; end
      DRAIN: state_d = DONE;
      default: begin
        if (bist_start_i) begin
          state_d = W0;
          addr_d  = '0;
          phase_d = 1'b0;
        end
      end
    endcase
    elem_last = elem_dn ? (addr_q == '0) : (addr_q == LastAddr);
    if (elem_act) begin
      if (elem_rd && elem_wr && !phase_q) begin
        eng_re  = 1'b1;
        phase_d = 1'b1;
      end else begin
        eng_re  = elem_rd && !elem_wr;
        eng_we  = elem_wr;
        phase_d = 1'b0;
        if (elem_last) begin
          state_d = elem_nxt;
          addr_d  = elem_start;
        end else begin
          addr_d  = elem_dn ? addr_q - 1'b1 : addr_q + 1'b1;
        end
      end
    end
    if (clear_i) begin
      state_d = IDLE;
      addr_d  = '0;
      phase_d = 1'b0;
    end
  end

  // Port arbitration: the engine owns address/data whenever it is busy
  assign gnt_o     = req_i && !busy;
  assign mem_we    = eng_we || (gnt_o && wen_i);
  assign mem_re    = eng_re || (gnt_o && !wen_i);
  assign mem_addr  = busy ? addr_q : addr_i;
  assign mem_wdata = busy ? {DataWidth{elem_wval}} : wdata_i;
  assign mem_be    = busy ? {NumBe{1'b1}} : be_i;

  generate
    if (RegfileScm != 0) begin : g_scm
      logic [NumRows*NumBe-1:0] gate_en;
      // Per row/byte write gates decoded up front, as the latch array's clock gates would be
      always_comb begin
        gate_en = '0;
        for (int r = 0; r < NumRows; r++)
          for (int b = 0; b < NumBe; b++)
            gate_en[r*NumBe+b] = mem_we && (mem_addr == AddrWidth'(r)) && mem_be[b];
      end
      // Storage array update through the gated byte lanes
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          mem_q <= '0;
        end else if (clear_i) begin
          mem_q <= '0;
        end else begin
          for (int i = 0; i < NumRows*NumBe; i++)
            if (gate_en[i]) mem_q[i*8 +: 8] <= mem_wdata[(i%NumBe)*8 +: 8];
        end
      end
    end else begin : g_ff
      // Storage array update with byte-enabled writes decoded in place
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          mem_q <= '0;
        end else if (clear_i) begin
          mem_q <= '0;
        end else if (mem_we) begin
          for (int b = 0; b < NumBe; b++)
            if (mem_be[b]) mem_q[int'(mem_addr)*DataWidth + b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
      end
    end
  endgenerate

  // Registered read port shared by functional reads and engine compares
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (clear_i) begin
      rdata_q <= '0;
    end else if (mem_re) begin
      rdata_q <= mem_q[int'(mem_addr)*DataWidth +: DataWidth];
    end
  end

  // Expected value and address travel one stage alongside the read
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmp_vld_q  <= 1'b0;
      cmp_exp_q  <= 1'b0;
      cmp_addr_q <= '0;
    end else begin
      cmp_vld_q  <= eng_re && !clear_i;
      cmp_exp_q  <= elem_exp;
      cmp_addr_q <= addr_q;
    end
  end

  // Sticky status: zeroed by start or clear, updated by the compare stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      err_cnt_q   <= '0;
    end else if (clear_i || start_acc) begin
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (state_q == DRAIN) done_q <= 1'b1;
      if (cmp_vld_q && (rdata_q != {DataWidth{cmp_exp_q}})) begin
        fail_q <= 1'b1;
        if (!fail_q) fail_addr_q <= cmp_addr_q;
        if (err_cnt_q != {CntWidth{1'b1}}) err_cnt_q <= err_cnt_q + CntWidth'(1);
      end
    end
  end

  assign rdata_o          = rdata_q;
  assign mem_content_o    = mem_q;
  assign bist_busy_o      = busy;
  assign bist_done_o      = done_q;
  assign bist_fail_o      = fail_q;
  assign bist_fail_addr_o = fail_addr_q;
  assign bist_err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_hwpe_ctrl_regfile_mbist_wrap.sv
// Directed bench for the regfile BIST wrapper: two instances (default latch config, small FF config).
// Inputs are driven and outputs sampled 1 time unit after the rising clock edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_hwpe_ctrl_regfile_mbist_wrap;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance 0: defaults (latch storage, 32 x 32, 8-bit counter)
  logic          clear0 = 0, req0 = 0, wen0 = 0, start0 = 0;
  logic          gnt0, busy0, done0, fail0;
  logic [4:0]    addr0 = '0, faddr0;
  logic [31:0]   wdata0 = '0, rdata0;
  logic [3:0]    be0 = '0;
  logic [1023:0] mem0;
  logic [7:0]    cnt0;

  // instance 1: FF storage, 8 rows x 16 bits, 6 words tested, 1-bit counter
  logic          clear1 = 0, req1 = 0, wen1 = 0, start1 = 0;
  logic          gnt1, busy1, done1, fail1;
  logic [2:0]    addr1 = '0, faddr1;
  logic [15:0]   wdata1 = '0, rdata1;
  logic [1:0]    be1 = '0;
  logic [127:0]  mem1;
  logic [0:0]    cnt1;

  hwpe_ctrl_regfile_mbist_wrap u0 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear0), .req_i(req0), .gnt_o(gnt0),
    .wen_i(wen0), .addr_i(addr0), .wdata_i(wdata0), .be_i(be0), .rdata_o(rdata0),
    .mem_content_o(mem0), .bist_start_i(start0), .bist_busy_o(busy0),
    .bist_done_o(done0), .bist_fail_o(fail0), .bist_fail_addr_o(faddr0),
    .bist_err_cnt_o(cnt0)
  );

  hwpe_ctrl_regfile_mbist_wrap #(
    .RegfileScm(0), .AddrWidth(3), .DataWidth(16), .NumWords(6), .CntWidth(1)
  ) u1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear1), .req_i(req1), .gnt_o(gnt1),
    .wen_i(wen1), .addr_i(addr1), .wdata_i(wdata1), .be_i(be1), .rdata_o(rdata1),
    .mem_content_o(mem1), .bist_start_i(start1), .bist_busy_o(busy1),
    .bist_done_o(done1), .bist_fail_o(fail1), .bist_fail_addr_o(faddr1),
    .bist_err_cnt_o(cnt1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [1023:0] act, input logic [1023:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // counts busy cycles until the selected instance goes idle, bounded
  task automatic wait_idle(input int inst, output int len);
    len = 0;
    while (((inst == 0) ? busy0 : busy1) && len < 2000) begin
      tick();
      len++;
    end
  endtask

  int len;
  int gnt_hi;

  initial begin
    // reset
    tick(); tick();
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_fail", fail0, 0);
    check("rst_cnt", cnt0, 0);
    check("rst_rdata", rdata0, 0);
    check("rst_mem", mem0, 0);
    rst_n = 1'b1;
    tick();

    // byte-enabled write then read
    req0 = 1; wen0 = 1; addr0 = 5'd3; wdata0 = 32'hDEADBEEF; be0 = 4'b0101;
    #1 check("wr_gnt", gnt0, 1);
    tick();
    wen0 = 0;
    tick();
    req0 = 0;
    check("rd_data", rdata0, 32'h00AD00EF);
    check("rd_mem3", mem0[3*32 +: 32], 32'h00AD00EF);

    // functional write and start in the same idle cycle, then a clean run
    req0 = 1; wen0 = 1; addr0 = 5'd5; wdata0 = 32'hAAAA5555; be0 = 4'hF; start0 = 1;
    #1 check("start_gnt", gnt0, 1);
    tick();
    start0 = 0;
    check("same_cyc_wr", mem0[5*32 +: 32], 32'hAAAA5555);
    check("busy_after_start", busy0, 1);
    addr0 = 5'd9; wdata0 = 32'hFFFFFFFF;
    len = 0; gnt_hi = 0;
    while (busy0 && len < 2000) begin
      if (gnt0) gnt_hi++;
      start0 = (len == 50);
      tick();
      len++;
    end
    req0 = 0; wen0 = 0; start0 = 0;
    check("clean_len", len, 321);
    check("busy_gnt", gnt_hi, 0);
    check("clean_done", done0, 1);
    check("clean_fail", fail0, 0);
    check("clean_cnt", cnt0, 0);
    check("clean_mem", mem0, 0);

    // stuck-at-1 on word 9 bit 7, started from DONE
    force u0.mem_q[295] = 1'b1;
    start0 = 1;
    tick();
    start0 = 0;
    check("sa1_started", done0, 0);
    wait_idle(0, len);
    check("sa1_len", len, 321);
    check("sa1_fail", fail0, 1);
    check("sa1_addr", faddr0, 9);
    check("sa1_cnt", cnt0, 3);

    // abort at cycle 100 with the fault still present
    start0 = 1;
    tick();
    start0 = 0;
    len = 0;
    while (busy0 && len < 100) begin
      tick();
      len++;
    end
    check("pre_clr_fail", fail0, 1);
    clear0 = 1;
    tick();
    clear0 = 0;
    check("clr_busy", busy0, 0);
    check("clr_done", done0, 0);
    check("clr_fail", fail0, 0);
    check("clr_cnt", cnt0, 0);
    release u0.mem_q[295];
    start0 = 1;
    tick();
    start0 = 0;
    wait_idle(0, len);
    check("rerun_len", len, 321);
    check("rerun_done", done0, 1);
    check("rerun_fail", fail0, 0);
    check("rerun_mem", mem0, 0);

    // small instance: untested top row keeps its data, stuck-at-0 on word 0 bit 0
    req1 = 1; wen1 = 1; addr1 = 3'd7; wdata1 = 16'h1234; be1 = 2'b11;
    tick();
    req1 = 0; wen1 = 0;
    force u1.mem_q[0] = 1'b0;
    start1 = 1;
    tick();
    start1 = 0;
    wait_idle(1, len);
    release u1.mem_q[0];
    check("u1_len", len, 61);
    check("u1_done", done1, 1);
    check("u1_fail", fail1, 1);
    check("u1_addr", faddr1, 0);
    check("u1_cnt_sat", cnt1, 1);
    check("u1_mem", mem1, {16'h1234, 112'h0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
